// File: rtl/ram_lane_init.sv
// Dual-port lane-masked RAM with a self-clearing sweep after reset or on request.
// One write port and one registered read port work in the same cycle. Byte lanes
// are written independently under w_mask. While busy, the controller writes zeros
// to every address in turn and both user ports are ignored.
module ram_lane_init #(
    parameter int unsigned AW     = 5,
    parameter int unsigned DW     = 8,
    parameter int unsigned DN     = 1,
    parameter bit          BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_en,
    input  logic [AW-1:0]    w_addr,
    input  logic [DN*DW-1:0] w_data,
    input  logic [DN-1:0]    w_mask,
    input  logic             r_en,
    input  logic [AW-1:0]    r_addr,
    output logic [DN*DW-1:0] r_data,
    output logic             r_valid,
    input  logic             init_req,
    output logic             busy
);

    localparam int unsigned WW    = DN * DW;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [0:0] {StInit, StIdle} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic            clr_last;
    logic            is_idle;
    logic [WW-1:0]   rd_word;
    logic [WW-1:0]   mem [DEPTH];

    // Terminal detection keeps the AW-bit sweep counter from wrapping unnoticed.
    assign clr_last = (clr_addr_q == {AW{1'b1}});

    // Controller state and sweep address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next-state logic: the sweep cannot be restarted by init_req, only by reset.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StInit: begin
                if (clr_last) begin
                    state_d    = StIdle;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            StIdle: begin
                if (init_req) begin
                    state_d    = StInit;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = StInit;
                clr_addr_d = '0;
            end
        endcase
    end

    // Controller outputs.
    always_comb begin
        busy    = (state_q == StInit);
        is_idle = (state_q == StIdle);
    end

    // Storage: sweep writes zeros, otherwise masked per-lane user writes.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_addr_q] <= '0;
        end else if (w_en) begin
            for (int i = 0; i < int'(DN); i++) begin
                if (w_mask[i]) begin
                    mem[w_addr][i*DW +: DW] <= w_data[i*DW +: DW];
                end
            end
        end
    end

    // Read word selection; write-first forwarding applies only to masked lanes.
    always_comb begin
        rd_word = mem[r_addr];
        if (BYPASS && w_en && (r_addr == w_addr)) begin
            for (int i = 0; i < int'(DN); i++) begin
                if (w_mask[i]) begin
                    rd_word[i*DW +: DW] = w_data[i*DW +: DW];
                end
            end
        end
    end

    // Registered read port; r_data holds when no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= is_idle && r_en;
            if (is_idle && r_en) begin
                r_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_ram_lane_init.sv
// Directed bench for ram_lane_init: one read-first and one write-first instance
// share all inputs; expected values are hand-computed constants.
module tb_ram_lane_init;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 8;
    localparam int unsigned DN = 2;

    logic             clk;
    logic             rst_n;
    logic             w_en;
    logic [AW-1:0]    w_addr;
    logic [DN*DW-1:0] w_data;
    logic [DN-1:0]    w_mask;
    logic             r_en;
    logic [AW-1:0]    r_addr;
    logic             init_req;
    logic [DN*DW-1:0] r_data_rf, r_data_wf;
    logic             r_valid_rf, r_valid_wf;
    logic             busy_rf, busy_wf;

    int checks;
    int failures;

    ram_lane_init #(.AW(AW), .DW(DW), .DN(DN), .BYPASS(1'b0)) dut_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_mask   (w_mask),
        .r_en     (r_en),
        .r_addr   (r_addr),
        .r_data   (r_data_rf),
        .r_valid  (r_valid_rf),
        .init_req (init_req),
        .busy     (busy_rf)
    );

    ram_lane_init #(.AW(AW), .DW(DW), .DN(DN), .BYPASS(1'b1)) dut_wf (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_mask   (w_mask),
        .r_en     (r_en),
        .r_addr   (r_addr),
        .r_data   (r_data_wf),
        .r_valid  (r_valid_wf),
        .init_req (init_req),
        .busy     (busy_wf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] m);
        w_en   = 1'b1;
        w_addr = a;
        w_data = d;
        w_mask = m;
        step();
        w_en   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [15:0] exp);
        r_en   = 1'b1;
        r_addr = a;
        step();
        r_en   = 1'b0;
        check_eq({tag, "_valid_rf"}, 32'(r_valid_rf), 32'd1);
        check_eq({tag, "_valid_wf"}, 32'(r_valid_wf), 32'd1);
        check_eq({tag, "_data_rf"}, 32'(r_data_rf), 32'(exp));
        check_eq({tag, "_data_wf"}, 32'(r_data_wf), 32'(exp));
    endtask

    // Count samples with busy high, bounded so a stuck controller cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        while (busy_rf && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        logic [15:0] v;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        w_en     = 1'b0;
        w_addr   = '0;
        w_data   = '0;
        w_mask   = '0;
        r_en     = 1'b0;
        r_addr   = '0;
        init_req = 1'b0;

        step();
        step();
        check_eq("rst_busy", 32'(busy_rf), 32'd1);
        check_eq("rst_busy_wf", 32'(busy_wf), 32'd1);
        check_eq("rst_valid", 32'(r_valid_rf), 32'd0);
        check_eq("rst_data", 32'(r_data_rf), 32'd0);

        // Power-up sweep lasts 32 cycles.
        rst_n = 1'b1;
        count_busy(n);
        check_eq("init_len", 32'(n), 32'd32);
        check_eq("init_done_wf", 32'(busy_wf), 32'd0);
        for (int i = 0; i < 32; i++) read_check("clr0", i[AW-1:0], 16'h0000);

        // Full-word writes and read-back, addr 6 lane0 carries -3.
        for (int i = 0; i < 8; i++) begin
            v = {8'(i + 1), 8'(i)};
            if (i == 6) v[7:0] = 8'hFD;
            write_word(i[AW-1:0], v, 2'b11);
        end
        for (int i = 0; i < 8; i++) begin
            v = {8'(i + 1), 8'(i)};
            if (i == 6) v[7:0] = 8'hFD;
            read_check("wr", i[AW-1:0], v);
        end
        step();
        check_eq("idle_valid", 32'(r_valid_rf), 32'd0);
        check_eq("idle_hold", 32'(r_data_rf), 32'h0807);
        check_eq("idle_hold_wf", 32'(r_data_wf), 32'h0807);

        // Lane mask: only lane 0 written.
        write_word(5'd3, 16'h0304, 2'b11);
        write_word(5'd3, 16'hAABB, 2'b01);
        read_check("mask", 5'd3, 16'h03BB);

        // Same-address collision, full mask.
        write_word(5'd5, 16'h0505, 2'b11);
        w_en = 1'b1; w_addr = 5'd5; w_data = 16'h1111; w_mask = 2'b11;
        r_en = 1'b1; r_addr = 5'd5;
        step();
        w_en = 1'b0; r_en = 1'b0;
        check_eq("coll_rf", 32'(r_data_rf), 32'h0505);
        check_eq("coll_wf", 32'(r_data_wf), 32'h1111);
        read_check("coll_after", 5'd5, 16'h1111);

        // Collision with partial mask: only lane 0 forwarded.
        w_en = 1'b1; w_addr = 5'd5; w_data = 16'h2222; w_mask = 2'b01;
        r_en = 1'b1; r_addr = 5'd5;
        step();
        w_en = 1'b0; r_en = 1'b0;
        check_eq("pcoll_rf", 32'(r_data_rf), 32'h1111);
        check_eq("pcoll_wf", 32'(r_data_wf), 32'h1122);

        // init_req: that cycle's read completes, then a 32-cycle sweep ignoring ports.
        init_req = 1'b1; r_en = 1'b1; r_addr = 5'd3;
        step();
        init_req = 1'b0; r_en = 1'b0;
        check_eq("req_read_valid", 32'(r_valid_rf), 32'd1);
        check_eq("req_read_data", 32'(r_data_rf), 32'h03BB);
        check_eq("req_busy", 32'(busy_rf), 32'd1);
        n = 0;
        while (busy_rf && n < 100) begin
            n++;
            w_en = 1'b1; w_addr = 5'd2; w_data = 16'hFFFF; w_mask = 2'b11;
            r_en = 1'b1; r_addr = 5'd3;
            step();
            check_eq("sweep_valid", 32'(r_valid_wf), 32'd0);
            check_eq("sweep_hold", 32'(r_data_rf), 32'h03BB);
        end
        w_en = 1'b0; r_en = 1'b0;
        check_eq("req_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) read_check("clr1", i[AW-1:0], 16'h0000);

        // Reset in the middle of a sweep (address 17).
        write_word(5'd1, 16'h1234, 2'b11);
        read_check("pre_rst", 5'd1, 16'h1234);
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int i = 0; i < 17; i++) step();
        check_eq("mid_busy", 32'(busy_rf), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_data", 32'(r_data_rf), 32'd0);
        check_eq("arst_data_wf", 32'(r_data_wf), 32'd0);
        check_eq("arst_valid", 32'(r_valid_rf), 32'd0);
        check_eq("arst_busy", 32'(busy_rf), 32'd1);
        step();
        rst_n = 1'b1;
        count_busy(n);
        check_eq("rst_len", 32'(n), 32'd32);
        read_check("post_rst", 5'd1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_lane_init.md
RAM_LANE_INIT -- requirements
Module: ram_lane_init

Interface
REQ-001 Parameter AW, default 5: address width; depth is 2^AW words.
REQ-002 Parameter DW, default 8: lane data width in bits.
REQ-003 Parameter DN, default 1: lanes per word; word width is DN*DW.
REQ-004 Parameter BYPASS, default 0: 1 = write-first on same-address collision, 0 = read-first.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 w_en  input  1  write enable.
REQ-008 w_addr  input  AW  write address.
REQ-009 w_data  input  DN*DW  write data; lane i occupies bits [i*DW +: DW].
REQ-010 w_mask  input  DN  per-lane write enable; bit i gates lane i.
REQ-011 r_en  input  1  read enable.
REQ-012 r_addr  input  AW  read address.
REQ-013 r_data  output  DN*DW  registered read data.
REQ-014 r_valid  output  1  high for one cycle when r_data carries a new read result.
REQ-015 init_req  input  1  request to re-clear the whole memory.
REQ-016 busy  output  1  high while the clear sweep runs.

Function
REQ-017 Storage: 2^AW words x DN lanes x DW bits, one write port and one read port, both usable in the same cycle.
REQ-018 Controller states: INIT and IDLE. busy = 1 in INIT, 0 in IDLE.
REQ-019 INIT: each cycle write all-zero to mem[clr_addr] and increment clr_addr; after writing address 2^AW-1, go to IDLE. The sweep lasts exactly 2^AW cycles.
REQ-020 INIT: ignore w_en and r_en, hold r_valid at 0 and hold r_data, and ignore init_req (no restart).
REQ-021 IDLE with init_req = 1 at an edge: complete that cycle's read and write normally, then enter INIT with clr_addr = 0 at the next cycle.
REQ-022 IDLE write: with w_en = 1 at an edge, update lane i of mem[w_addr] with w_data lane i for every i where w_mask[i] = 1; leave unmasked lanes unchanged.
REQ-023 IDLE read: with r_en = 1 at edge k, after edge k r_data = mem[r_addr] and r_valid = 1 (latency 1).
REQ-024 With r_en = 0, r_valid = 0 after the edge and r_data holds its previous value.
REQ-025 Collision (r_en, w_en, r_addr == w_addr in the same cycle):
- BYPASS = 1: masked lanes return w_data, unmasked lanes return stored data.
- BYPASS = 0: all lanes return pre-write data.
REQ-026 Addresses are full AW-bit values with no out-of-range case; the clr_addr counter is AW+1 bits or has explicit terminal detection so the sweep does not wrap silently.

Reset
REQ-027 Asserting rst_n low asynchronously sets r_data = 0, r_valid = 0, state = INIT, clr_addr = 0, busy = 1.
REQ-028 Memory contents are not reset directly; after rst_n rises they are cleared by the INIT sweep.
REQ-029 Reset asserted during an INIT sweep restarts the sweep from address 0 after release; reset asserted during IDLE discards any in-flight read result.

Verification (AW=5, DW=8, DN=2 unless stated)
REQ-030 Release rst_n -> busy = 1 for exactly 32 cycles, then 0; reading addresses 0..31 returns 0x0000 with r_valid = 1 one cycle after each r_en.
REQ-031 Write addr i with {i+1, i} for i = 0..7 under mask 2'b11, including addr 6 lane0 = 0xFD (-3); read back -> values match with 1-cycle latency; r_en = 0 cycle -> r_valid = 0 and r_data held.
REQ-032 addr 3 holds 0x0304; write 0xAABB with mask 2'b01 -> read returns 0x03BB.
REQ-033 Same-cycle write 0x1111 and read at addr 5 (old 0x0505), mask 2'b11 -> BYPASS = 1 gives 0x1111; BYPASS = 0 gives 0x0505, and the next read gives 0x1111.
REQ-034 init_req pulse in IDLE -> busy rises the next cycle and stays high for 32 cycles; writes and reads during the sweep are ignored with r_valid = 0; afterwards every address reads 0x0000.
REQ-035 rst_n low at sweep address 17 -> r_data = 0 and r_valid = 0 immediately; after release busy = 1 for a full 32 cycles.
